// File: rtl/imem_stream_loader.sv
// Module: imem_stream_loader
//
// Receives a program image as a byte stream. It assembles the bytes into 32-bit words and
// writes each word into the instruction memory of iitk_mini_mips through the core's
// init port. The core stays in reset and load mode until the whole image is written.
//
// Image format: a 2-byte word count N, MSB first, followed by N words. Each word is
// 4 bytes, MSB first.
//
// Ports
//   clk              system clock; all logic runs on the rising edge
//   reset_n          synchronous active-low reset
//   start            single-cycle pulse that begins a new load (honoured in IDLE, RUN and ERROR)
//   in_valid         byte stream valid
//   in_data          byte stream data
//   in_ready         the loader accepts a byte in this cycle
//   init_mode        to core: load mode (PC frozen)
//   write_enable     to core: single-cycle instruction write strobe
//   init_address     to core: word address of the current write
//   init_instruction to core: word being written
//   core_reset       to core: active-high reset
//   busy             a load is in progress (header through reset hold)
//   done             the image is loaded and the core is running
//   error            the header word count exceeded DEPTH
//   words_loaded     words written in the current or last load
module imem_stream_loader #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              init_mode,
    output logic              write_enable,
    output logic [ADDR_W-1:0] init_address,
    output logic [31:0]       init_instruction,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StLoad,
        StWrite,
        StDone,
        StRun,
        StError
    } state_e;

    state_e            state_q;
    logic [15:0]       count_q;
    logic [23:0]       word_q;
    logic [1:0]        byte_cnt_q;
    logic [RCW-1:0]    rst_cnt_q;

    logic              in_ready_q;
    logic              init_mode_q;
    logic              write_enable_q;
    logic [ADDR_W-1:0] init_address_q;
    logic [31:0]       init_instruction_q;
    logic              core_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W:0]   words_loaded_q;

    logic              accept;
    logic [15:0]       hdr_count;
    logic              count_over;
    logic              last_word;

    // in_ready_q is already a function of state, so a qualified byte needs no state decode.
    assign accept     = in_valid && in_ready_q;
    assign hdr_count  = {count_q[15:8], in_data};
    assign count_over = 32'(hdr_count) > DEPTH;
    // The count is non-zero whenever WRITE is reached, so count-1 cannot underflow here.
    assign last_word  = 32'(init_address_q) == (32'(count_q) - 32'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q            <= StIdle;
            count_q            <= '0;
            word_q             <= '0;
            byte_cnt_q         <= '0;
            rst_cnt_q          <= '0;
            in_ready_q         <= 1'b0;
            init_mode_q        <= 1'b1;
            write_enable_q     <= 1'b0;
            init_address_q     <= '0;
            init_instruction_q <= '0;
            core_reset_q       <= 1'b1;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            error_q            <= 1'b0;
            words_loaded_q     <= '0;
        end else begin
            // The write strobe is a single-cycle pulse. It is raised only on entry to WRITE.
            write_enable_q <= 1'b0;

            unique case (state_q)
                StIdle, StRun, StError: begin
                    // in_ready is low in these states, so a byte that arrives together with
                    // start is not consumed.
                    if (start) begin
                        state_q        <= StHdrHi;
                        in_ready_q     <= 1'b1;
                        init_mode_q    <= 1'b1;
                        core_reset_q   <= 1'b1;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                        words_loaded_q <= '0;
                        init_address_q <= '0;
                        byte_cnt_q     <= '0;
                    end
                end

                StHdrHi: begin
                    if (accept) begin
                        count_q[15:8] <= in_data;
                        state_q       <= StHdrLo;
                    end
                end

                StHdrLo: begin
                    if (accept) begin
                        count_q[7:0] <= in_data;
                        if (hdr_count == 16'd0) begin
                            state_q    <= StDone;
                            in_ready_q <= 1'b0;
                            rst_cnt_q  <= '0;
                        end else if (count_over) begin
                            state_q    <= StError;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end

                StLoad: begin
                    if (accept) begin
                        if (byte_cnt_q == 2'd3) begin
                            // The 4th byte goes straight into the output word. Only the
                            // first three bytes are held in word_q.
                            init_instruction_q <= {word_q, in_data};
                            write_enable_q     <= 1'b1;
                            in_ready_q         <= 1'b0;
                            byte_cnt_q         <= '0;
                            state_q            <= StWrite;
                        end else begin
                            word_q     <= {word_q[15:0], in_data};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end

                StWrite: begin
                    words_loaded_q <= words_loaded_q + 1'b1;
                    if (last_word) begin
                        // The address holds at the last index. It never wraps, because
                        // N <= DEPTH.
                        state_q   <= StDone;
                        rst_cnt_q <= '0;
                    end else begin
                        init_address_q <= init_address_q + 1'b1;
                        in_ready_q     <= 1'b1;
                        state_q        <= StLoad;
                    end
                end

                StDone: begin
                    if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
                        state_q      <= StRun;
                        init_mode_q  <= 1'b0;
                        core_reset_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready         = in_ready_q;
    assign init_mode        = init_mode_q;
    assign write_enable     = write_enable_q;
    assign init_address     = init_address_q;
    assign init_instruction = init_instruction_q;
    assign core_reset       = core_reset_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign words_loaded     = words_loaded_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DEPTH      = 4096;
    localparam int unsigned RST_CYCLES = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              init_mode;
    logic              write_enable;
    logic [ADDR_W-1:0] init_address;
    logic [31:0]       init_instruction;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]        img[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    imem_stream_loader #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .init_mode       (init_mode),
        .write_enable    (write_enable),
        .init_address    (init_address),
        .init_instruction(init_instruction),
        .core_reset      (core_reset),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .words_loaded    (words_loaded)
    );

    always #5 clk = ~clk;

    // Record every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (write_enable) begin
            wr_addr.push_back(init_address);
            wr_data.push_back(init_instruction);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},     64'(in_ready),         64'd0);
        check({tag, "_init_mode"},    64'(init_mode),        64'd1);
        check({tag, "_we"},           64'(write_enable),     64'd0);
        check({tag, "_addr"},         64'(init_address),     64'd0);
        check({tag, "_instr"},        64'(init_instruction), 64'd0);
        check({tag, "_core_reset"},   64'(core_reset),       64'd1);
        check({tag, "_busy"},         64'(busy),             64'd0);
        check({tag, "_done"},         64'(done),             64'd0);
        check({tag, "_error"},        64'(error),            64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded),     64'd0);
    endtask

    task automatic add_hdr(input int unsigned n);
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
    endtask

    task automatic add_word(input logic [31:0] w);
        img.push_back(w[31:24]);
        img.push_back(w[23:16]);
        img.push_back(w[15:8]);
        img.push_back(w[7:0]);
    endtask

    // Called at a negedge and returns at a negedge. The byte is consumed on the posedge
    // between the two.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        int g;
        t = 0;
        g = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1 && g < 8) begin
                g++;
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) check("rdy_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hxx;
    endtask

    task automatic send_img(input bit gaps);
        while (img.size() > 0) send_byte(img.pop_front(), gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts the negedges on which core_reset is still high.
    task automatic wait_release(output int n);
        n = 0;
        while (core_reset && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("release", 64'(core_reset), 64'd0);
    endtask

    task automatic check_run(input string tag, input int unsigned nwords);
        check({tag, "_init_mode"},    64'(init_mode),    64'd0);
        check({tag, "_core_reset"},   64'(core_reset),   64'd0);
        check({tag, "_done"},         64'(done),         64'd1);
        check({tag, "_busy"},         64'(busy),         64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(nwords));
    endtask

    logic [31:0] w3[3];
    int          n;

    initial begin
        w3[0] = 32'h0123_4567;
        w3[1] = 32'h89AB_CDEF;
        w3[2] = 32'hDEAD_BEEF;

        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // 1: two-word image. A byte that arrives together with start must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("t1_hdr_ready", 64'(in_ready), 64'd1);
        check("t1_hdr_busy",  64'(busy),     64'd1);
        add_hdr(2);
        add_word(32'h2008_0005);
        add_word(32'h2009_000A);
        send_img(1'b0);
        check("t1_we", 64'(write_enable), 64'd1);
        @(negedge clk);
        wait_release(n);
        check("t1_rst_cycles", 64'(n), 64'd4);
        check_run("t1", 2);
        check("t1_nwr", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            check("t1_a0", 64'(wr_addr[0]), 64'd0);
            check("t1_d0", 64'(wr_data[0]), 64'h2008_0005);
            check("t1_a1", 64'(wr_addr[1]), 64'd1);
            check("t1_d1", 64'(wr_data[1]), 64'h2009_000A);
        end
        wr_addr.delete();
        wr_data.delete();

        // 2: empty image.
        pulse_start();
        check("t2_done_drop", 64'(done),         64'd0);
        check("t2_wl_clear",  64'(words_loaded), 64'd0);
        add_hdr(0);
        send_img(1'b0);
        wait_release(n);
        check("t2_rst_cycles", 64'(n), 64'd4);
        check_run("t2", 0);
        check("t2_nwr", 64'(wr_addr.size()), 64'd0);

        // 3: oversize header.
        pulse_start();
        add_hdr(4097);
        send_img(1'b0);
        check("t3_error",      64'(error),      64'd1);
        check("t3_in_ready",   64'(in_ready),   64'd0);
        check("t3_init_mode",  64'(init_mode),  64'd1);
        check("t3_core_reset", 64'(core_reset), 64'd1);
        check("t3_done",       64'(done),       64'd0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("t3_error_hold", 64'(error),    64'd1);
        check("t3_ready_hold", 64'(in_ready), 64'd0);
        pulse_start();
        check("t3_error_clr", 64'(error),    64'd0);
        check("t3_restart",   64'(in_ready), 64'd1);
        check("t3_busy",      64'(busy),     64'd1);

        // 4a: gap-free three-word image. A start pulse in mid-load must be ignored.
        add_hdr(3);
        img.push_back(w3[0][31:24]);
        img.push_back(w3[0][23:16]);
        send_img(1'b0);
        pulse_start();
        check("t4_busy_start", 64'(busy),     64'd1);
        check("t4_ready_keep", 64'(in_ready), 64'd1);
        img.push_back(w3[0][15:8]);
        img.push_back(w3[0][7:0]);
        add_word(w3[1]);
        add_word(w3[2]);
        send_img(1'b0);
        @(negedge clk);
        wait_release(n);
        check_run("t4a", 3);
        check("t4a_nwr", 64'(wr_addr.size()), 64'd3);
        if (wr_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t4a_addr", 64'(wr_addr[i]), 64'(i));
                check("t4a_data", 64'(wr_data[i]), 64'(w3[i]));
            end
        end
        wr_addr.delete();
        wr_data.delete();

        // 4b: the same image with random valid gaps.
        pulse_start();
        add_hdr(3);
        for (int i = 0; i < 3; i++) add_word(w3[i]);
        send_img(1'b1);
        @(negedge clk);
        wait_release(n);
        check_run("t4b", 3);
        check("t4b_nwr", 64'(wr_addr.size()), 64'd3);
        if (wr_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t4b_addr", 64'(wr_addr[i]), 64'(i));
                check("t4b_data", 64'(wr_data[i]), 64'(w3[i]));
            end
        end
        wr_addr.delete();
        wr_data.delete();

        // 5: reset during byte 3 of word 2.
        pulse_start();
        add_hdr(3);
        add_word(32'h1122_3344);
        img.push_back(8'h55);
        img.push_back(8'h66);
        send_img(1'b0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        reset_n  = 1'b0;
        @(negedge clk);
        check_reset_vals("t5_rst");
        check("t5_nwr_before", 64'(wr_addr.size()), 64'd1);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        add_hdr(1);
        add_word(32'h1234_5678);
        send_img(1'b0);
        @(negedge clk);
        wait_release(n);
        check_run("t5", 1);
        check("t5_nwr", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            check("t5_a0", 64'(wr_addr[0]), 64'd0);
            check("t5_d0", 64'(wr_data[0]), 64'h1234_5678);
        end
        wr_addr.delete();
        wr_data.delete();

        // 6: reload from RUN.
        pulse_start();
        check("t6_done",       64'(done),       64'd0);
        check("t6_init_mode",  64'(init_mode),  64'd1);
        check("t6_core_reset", 64'(core_reset), 64'd1);
        add_hdr(1);
        add_word(32'hAABB_CCDD);
        send_img(1'b0);
        @(negedge clk);
        wait_release(n);
        check_run("t6", 1);
        check("t6_nwr", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            check("t6_a0", 64'(wr_addr[0]), 64'd0);
            check("t6_d0", 64'(wr_data[0]), 64'hAABB_CCDD);
        end
        wr_addr.delete();
        wr_data.delete();

        // 7: N == DEPTH is legal and ends at address DEPTH-1.
        pulse_start();
        add_hdr(DEPTH);
        for (int i = 0; i < int'(DEPTH); i++) add_word(32'hC0DE_0000 | 32'(i));
        send_img(1'b0);
        @(negedge clk);
        wait_release(n);
        check_run("t7", DEPTH);
        check("t7_error", 64'(error), 64'd0);
        check("t7_nwr", 64'(wr_addr.size()), 64'(DEPTH));
        if (wr_addr.size() == DEPTH) begin
            check("t7_a_first", 64'(wr_addr[0]),         64'd0);
            check("t7_d_first", 64'(wr_data[0]),         64'hC0DE_0000);
            check("t7_a_last",  64'(wr_addr[DEPTH - 1]), 64'(DEPTH - 1));
            check("t7_d_last",  64'(wr_data[DEPTH - 1]), 64'hC0DE_0FFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
